// File: rtl/axi_burst_addr_gen_pkg.sv
// Shared AXI burst types and constants used by the burst address generator.
// Also provides the widest legal transfer size for a given data bus width.
package axi_burst_addr_gen_pkg;

  typedef enum logic [2:0] {
    SIZE_1B   = 3'd0,
    SIZE_2B   = 3'd1,
    SIZE_4B   = 3'd2,
    SIZE_8B   = 3'd3,
    SIZE_16B  = 3'd4,
    SIZE_32B  = 3'd5,
    SIZE_64B  = 3'd6,
    SIZE_128B = 3'd7
  } axi_burst_size;

  typedef enum logic [1:0] {
    BURST_FIXED = 2'b00,
    BURST_INCR  = 2'b01,
    BURST_WRAP  = 2'b10,
    BURST_RSVD  = 2'b11
  } axi_burst_type;

  localparam int unsigned AXI_4KB_BOUNDARY = 4096;

  function automatic int unsigned max_size(input int unsigned data_width);
    return $clog2(data_width / 8);
  endfunction

endpackage

// File: rtl/axi_burst_addr_gen_beat_calc.sv
// Combinational next-beat address for FIXED/INCR/WRAP bursts.
// Arithmetic is modulo 2^ADDR_WIDTH by construction.
module axi_beat_addr_calc
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32
) (
  input  logic [ADDR_WIDTH-1:0] cur_addr,
  input  logic [ADDR_WIDTH-1:0] start_addr,
  input  logic [7:0]            len,
  input  axi_burst_size         size,
  input  axi_burst_type         burst,
  output logic [ADDR_WIDTH-1:0] next_addr
);

  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [ADDR_WIDTH-1:0] bytes;
  logic [ADDR_WIDTH-1:0] size_mask;
  logic [ADDR_WIDTH-1:0] wrap_mask;
  logic [ADDR_WIDTH-1:0] incr_addr;

  always_comb begin
    bytes     = ONE << size;
    size_mask = bytes - ONE;
    wrap_mask = ((ADDR_WIDTH'(len) + ONE) << size) - ONE;
    // Align the current address first so an unaligned beat 0 snaps onto the size grid.
    incr_addr = (cur_addr & ~size_mask) + bytes;
    next_addr = start_addr;
    case (burst)
      BURST_INCR: next_addr = incr_addr;
      BURST_WRAP: next_addr = (cur_addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default:    next_addr = start_addr;
    endcase
  end

endmodule

// File: rtl/axi_burst_addr_gen.sv
// Expands one AXI burst command into per-beat addresses with valid/ready handshake.
// Illegal commands are still accepted and answered with a single error beat.
module axi_burst_addr_gen
  import axi_burst_addr_gen_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  cmd_valid_i,
  output logic                  cmd_ready_o,
  input  logic [ADDR_WIDTH-1:0] cmd_addr_i,
  input  logic [7:0]            cmd_len_i,
  input  logic [2:0]            cmd_size_i,
  input  logic [1:0]            cmd_burst_i,
  output logic                  beat_valid_o,
  input  logic                  beat_ready_i,
  output logic [ADDR_WIDTH-1:0] beat_addr_o,
  output logic [7:0]            beat_idx_o,
  output logic                  beat_last_o,
  output logic                  beat_err_o
);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] BURST = 1'b1;

  localparam int unsigned MAX_SIZE  = max_size(DATA_WIDTH);
  localparam int unsigned PAGE_BITS = $clog2(AXI_4KB_BOUNDARY);
  localparam logic [ADDR_WIDTH-1:0] ONE = {{(ADDR_WIDTH-1){1'b0}}, 1'b1};

  logic [0:0]            state;
  logic                  cmd_ready_q;
  logic                  beat_valid_q;
  logic [ADDR_WIDTH-1:0] beat_addr_q;
  logic [7:0]            beat_idx_q;
  logic                  beat_last_q;
  logic                  beat_err_q;
  logic [ADDR_WIDTH-1:0] start_q;
  logic [7:0]            len_q;
  axi_burst_size         size_q;
  axi_burst_type         burst_q;
  logic [ADDR_WIDTH-1:0] next_addr;

  logic [ADDR_WIDTH-1:0] cmd_bytes;
  logic [16:0]           page_off;
  logic [16:0]           span;
  logic                  wrap_len_ok;
  logic                  cmd_illegal;

  always_comb begin
    cmd_bytes   = ONE << cmd_size_i;
    span        = (17'(cmd_len_i) + 17'd1) << cmd_size_i;
    // Last byte is measured from the size-aligned start within its 4 KB page.
    page_off    = 17'(cmd_addr_i[PAGE_BITS-1:0] & ~(cmd_bytes[PAGE_BITS-1:0] - 1'b1));
    wrap_len_ok = (cmd_len_i == 8'd1) || (cmd_len_i == 8'd3) ||
                  (cmd_len_i == 8'd7) || (cmd_len_i == 8'd15);
    cmd_illegal = 1'b0;
    if (32'(cmd_size_i) > MAX_SIZE)
      cmd_illegal = 1'b1;
    if (cmd_burst_i == BURST_RSVD)
      cmd_illegal = 1'b1;
    if (cmd_burst_i == BURST_WRAP &&
        (!wrap_len_ok || |(cmd_addr_i & (cmd_bytes - ONE))))
      cmd_illegal = 1'b1;
    if (cmd_burst_i == BURST_INCR && (page_off + span) > 17'(AXI_4KB_BOUNDARY))
      cmd_illegal = 1'b1;
  end

  axi_beat_addr_calc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_calc (
    .cur_addr  (beat_addr_q),
    .start_addr(start_q),
    .len       (len_q),
    .size      (size_q),
    .burst     (burst_q),
    .next_addr (next_addr)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state        <= IDLE;
      cmd_ready_q  <= 1'b0;
      beat_valid_q <= 1'b0;
      beat_addr_q  <= '0;
      beat_idx_q   <= '0;
      beat_last_q  <= 1'b0;
      beat_err_q   <= 1'b0;
      start_q      <= '0;
      len_q        <= '0;
      size_q       <= SIZE_1B;
      burst_q      <= BURST_FIXED;
    end else begin
      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_q) begin
            state        <= BURST;
            cmd_ready_q  <= 1'b0;
            beat_valid_q <= 1'b1;
            beat_addr_q  <= cmd_addr_i;
            beat_idx_q   <= '0;
            beat_err_q   <= cmd_illegal;
            beat_last_q  <= cmd_illegal || (cmd_len_i == 8'd0);
            start_q      <= cmd_addr_i;
            len_q        <= cmd_len_i;
            size_q       <= axi_burst_size'(cmd_size_i);
            burst_q      <= axi_burst_type'(cmd_burst_i);
          end else begin
            cmd_ready_q <= 1'b1;
          end
        end
        BURST: begin
          if (beat_ready_i) begin
            if (beat_last_q) begin
              state        <= IDLE;
              cmd_ready_q  <= 1'b1;
              beat_valid_q <= 1'b0;
              beat_last_q  <= 1'b0;
              beat_err_q   <= 1'b0;
            end else begin
              beat_addr_q <= next_addr;
              beat_idx_q  <= beat_idx_q + 8'd1;
              beat_last_q <= (beat_idx_q + 8'd1) == len_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign cmd_ready_o  = cmd_ready_q;
  assign beat_valid_o = beat_valid_q;
  assign beat_addr_o  = beat_addr_q;
  assign beat_idx_o   = beat_idx_q;
  assign beat_last_o  = beat_last_q;
  assign beat_err_o   = beat_err_q;

endmodule
